// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with PC, BTB prediction and IF/ID register.
// Ports: clk/rst (sync, active-high); imem_addr/imem_data fetch path;
//   stall/redirect/redirect_pc pipeline control; upd_* BTB training;
//   id_* IF/ID outputs to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);

    localparam int          IDX = $clog2(BTB_ENTRIES);
    localparam int          TW  = 30 - IDX;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]            r_pc;
    logic [BTB_ENTRIES-1:0] r_btb_v;
    logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
    logic [29:0]            r_btb_tgt [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr [BTB_ENTRIES];

    logic [IDX-1:0] w_lk_idx;
    logic           w_lk_hit;
    logic           w_pred_taken;
    logic [31:0]    w_pred_target;
    logic [31:0]    w_next_pc;
    logic [IDX-1:0] w_up_idx;
    logic [TW-1:0]  w_up_tag;
    logic           w_up_hit;
    logic           w_unused;

    // Low address bits are forced to zero, so these inputs bits are dropped.
    assign w_unused = ^{redirect_pc[1:0], upd_target[1:0], upd_pc[1:0]};

    assign imem_addr = r_pc;

    // Lookup on the current PC.
    assign w_lk_idx      = r_pc[IDX+1:2];
    assign w_lk_hit      = r_btb_v[w_lk_idx]
                        && (r_btb_tag[w_lk_idx] == r_pc[31:IDX+2]);
    assign w_pred_taken  = w_lk_hit && r_btb_ctr[w_lk_idx][1];
    assign w_pred_target = {r_btb_tgt[w_lk_idx], 2'b00};

    // Training lookup on the resolved PC.
    assign w_up_idx = upd_pc[IDX+1:2];
    assign w_up_tag = upd_pc[31:IDX+2];
    assign w_up_hit = r_btb_v[w_up_idx] && (r_btb_tag[w_up_idx] == w_up_tag);

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (redirect) begin
            w_next_pc = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            id_valid       <= 1'b0;
            id_pc          <= 32'd0;
            id_inst        <= NOP;
            id_pred_taken  <= 1'b0;
            id_pred_target <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (redirect) begin
                id_valid       <= 1'b0;
                id_pc          <= 32'd0;
                id_inst        <= NOP;
                id_pred_taken  <= 1'b0;
                id_pred_target <= 32'd0;
            end else if (!stall) begin
                id_valid       <= 1'b1;
                id_pc          <= r_pc;
                id_inst        <= imem_data;
                id_pred_taken  <= w_pred_taken;
                id_pred_target <= w_pred_taken ? w_pred_target : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_v <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= '0;
                r_btb_ctr[i] <= 2'd1;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    if (r_btb_ctr[w_up_idx] != 2'd3) begin
                        r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] + 2'd1;
                    end
                    r_btb_tgt[w_up_idx] <= upd_target[31:2];
                end else if (r_btb_ctr[w_up_idx] != 2'd0) begin
                    r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                r_btb_v[w_up_idx]   <= 1'b1;
                r_btb_tag[w_up_idx] <= w_up_tag;
                r_btb_tgt[w_up_idx] <= upd_target[31:2];
                r_btb_ctr[w_up_idx] <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Stimulus pushes expected IF/ID contents; a monitor pops and compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign imem_data = mem(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    // One unstalled fetch at pc; expectation queued for the IF/ID load.
    task automatic fetch(input logic [31:0] pc, input logic pt,
                         input logic [31:0] tg);
        exp_t e;
        chk("imem_addr", imem_addr, pc);
        e.pc   = pc;
        e.inst = mem(pc);
        e.pt   = pt;
        e.ptgt = pt ? tg : 32'd0;
        q.push_back(e);
        cyc();
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect = 1'b0;
        chk("bubble_valid", {31'd0, id_valid}, 32'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
    endtask

    // Monitor: compare whenever IF/ID was freshly loaded at the last edge.
    initial begin
        logic fresh;
        exp_t e;
        forever begin
            @(posedge clk);
            fresh = !rst && !redirect && !stall;
            @(negedge clk);
            if (fresh) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_load: got pc %08h want none",
                             id_pc);
                end else begin
                    e = q.pop_front();
                    if (id_valid !== 1'b1 || id_pc !== e.pc ||
                        id_inst !== e.inst || id_pred_taken !== e.pt ||
                        id_pred_target !== e.ptgt) begin
                        miscompares++;
                        $display("FAIL ifid: got v%0b pc %08h inst %08h pt %0b tgt %08h want v1 pc %08h inst %08h pt %0b tgt %08h",
                                 id_valid, id_pc, id_inst, id_pred_taken,
                                 id_pred_target, e.pc, e.inst, e.pt, e.ptgt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc();
        cyc();
        // Reset state.
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'h13);
        chk("rst_pc", id_pc, 32'h0);
        rst = 1'b0;

        fetch(32'h00, 0, 0);
        fetch(32'h04, 0, 0);
        fetch(32'h08, 0, 0);
        fetch(32'h0C, 0, 0);

        // Stall three cycles at 0x10.
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_addr", imem_addr, 32'h10);
            chk("stall_idpc", id_pc, 32'h0C);
        end
        stall = 1'b0;
        fetch(32'h10, 0, 0);
        fetch(32'h14, 0, 0);

        // Redirect with misaligned target beats a simultaneous stall.
        stall = 1'b1;
        redir(32'h43);
        stall = 1'b0;
        fetch(32'h40, 0, 0);

        // Train 0x20 taken -> 0x100.
        upd(32'h20, 1, 32'h100);
        fetch(32'h44, 0, 0);
        upd_valid = 1'b0;
        redir(32'h20);
        fetch(32'h20, 1, 32'h100);
        fetch(32'h100, 0, 0);

        // Two not-taken: ctr 2 -> 0.
        upd(32'h20, 0, 32'h0);
        fetch(32'h104, 0, 0);
        fetch(32'h108, 0, 0);
        upd_valid = 1'b0;
        redir(32'h20);
        fetch(32'h20, 0, 0);
        fetch(32'h24, 0, 0);

        // One taken: ctr 0 -> 1, still not taken.
        upd(32'h20, 1, 32'h100);
        fetch(32'h28, 0, 0);
        upd_valid = 1'b0;
        redir(32'h20);
        fetch(32'h20, 0, 0);
        fetch(32'h24, 0, 0);

        // Alias: 0x20 taken (ctr 2), then 0x60 evicts it.
        upd(32'h20, 1, 32'h200);
        fetch(32'h28, 0, 0);
        upd(32'h60, 1, 32'h303);
        fetch(32'h2C, 0, 0);
        upd_valid = 1'b0;
        redir(32'h20);
        fetch(32'h20, 0, 0);
        fetch(32'h24, 0, 0);
        redir(32'h60);
        fetch(32'h60, 1, 32'h300);
        fetch(32'h300, 0, 0);

        // PC wrap.
        redir(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 0, 0);
        fetch(32'h0, 0, 0);

        // Reset mid-stream, over stall and redirect.
        rst         = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_valid", {31'd0, id_valid}, 32'd0);
        chk("mrst_pc", id_pc, 32'h0);
        chk("mrst_inst", id_inst, 32'h13);
        chk("mrst_pt", {31'd0, id_pred_taken}, 32'd0);
        chk("mrst_tgt", id_pred_target, 32'h0);
        rst      = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;

        // BTB was cleared: 0x60 no longer predicts.
        redir(32'h60);
        fetch(32'h60, 0, 0);
        fetch(32'h64, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
